// File: rtl/onehot_seq_encoder_if.sv
// onehot_seq_encoder_if: request-vector input stream and encoded-index output stream.
// Optional out_maj signal present when ONEHOT_SEQ_ENCODER_MAJ_EN is defined.
interface onehot_seq_encoder_if #(parameter int N = 8);
    localparam int W = $clog2(N);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_none;
`ifdef ONEHOT_SEQ_ENCODER_MAJ_EN
    logic         out_maj;
    modport master(output in_valid, in_vec, out_ready,
                   input in_ready, out_valid, out_idx, out_last, out_none, out_maj);
    modport slave(input in_valid, in_vec, out_ready,
                  output in_ready, out_valid, out_idx, out_last, out_none, out_maj);
`else
    modport master(output in_valid, in_vec, out_ready,
                   input in_ready, out_valid, out_idx, out_last, out_none);
    modport slave(input in_valid, in_vec, out_ready,
                  output in_ready, out_valid, out_idx, out_last, out_none);
`endif
endinterface

// File: rtl/onehot_seq_encoder.sv
// onehot_seq_encoder: emits the index of every set bit of a captured vector, lowest first.
// Define ONEHOT_SEQ_ENCODER_MAJ_EN to add out_maj (strict popcount majority of the vector).
module onehot_seq_encoder #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    onehot_seq_encoder_if.slave bus
);
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       r_state, w_next;
    logic [N-1:0] r_pending;
    logic         r_zero;
    logic [N-1:0] w_rest;
    logic [W-1:0] w_idx;
    logic         w_last, w_in_fire, w_out_fire;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_in_fire  = bus.in_valid && r_state == IDLE;
        w_out_fire = bus.out_ready && r_state == EMIT;
        w_rest     = r_pending & (r_pending - N'(1));
        w_last     = w_rest == '0;
        w_next     = r_state;
        if (w_in_fire) w_next = EMIT;
        else if (w_out_fire && w_last) w_next = IDLE;
    end

    // descending scan so the lowest set bit is the final assignment
    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (r_pending[i]) w_idx = W'(i);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_pending <= '0;
            r_zero    <= 1'b0;
        end else if (w_in_fire) begin
            r_pending <= bus.in_vec;
            r_zero    <= bus.in_vec == '0;
        end else if (w_out_fire) begin
            r_pending <= w_rest;
        end

    assign bus.in_ready  = r_state == IDLE;
    assign bus.out_valid = r_state == EMIT;
    assign bus.out_idx   = r_state == EMIT ? w_idx : '0;
    assign bus.out_last  = r_state == EMIT && w_last;
    assign bus.out_none  = r_state == EMIT && r_zero;

`ifdef ONEHOT_SEQ_ENCODER_MAJ_EN
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] w_cnt;
    logic          r_maj;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++) w_cnt = w_cnt + CW'(bus.in_vec[i]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_maj <= 1'b0;
        else if (w_in_fire) r_maj <= w_cnt > CW'(N / 2);

    assign bus.out_maj = r_state == EMIT && r_maj;
`endif
endmodule
